kernel_sysid_checker: RTL and testbench

- Boot-time controller that sequences reads of the system-ID control slave over a 1-bit-address Avalon-MM master port.
- Word 0 is the system ID and word 1 is the build timestamp; both are compared against parameterised expected values.
- Sits between the reset controller and the CPU. `cpu_release` is held low until the check passes.
- Sequence: read word 0, read word 1, compare, report. Retry on timeout or mismatch.

---
 rtl/kernel_sysid_pkg.sv | 28 ++
 rtl/kernel_sysid_checker_if.sv | 27 ++
 rtl/kernel_sysid_wdog.sv | 35 +++
 rtl/kernel_sysid_checker.sv | 227 ++++++++++++++++++++++
 tb/tb_kernel_sysid_checker.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/kernel_sysid_pkg.sv
// Shared types and constants for the system-ID boot checker.
//   sysid_state_e : controller FSM states
//   sysid_cause_e : failure cause remembered across a retry
//   SYSID_ADDR_*  : word addresses on the 1-bit Avalon-MM slave
//   SYSID_WDOG_W  : width of the read-stall watchdog (TIMEOUT_CYCLES <= 255)
package kernel_sysid_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRdId,
    StRdTs,
    StCheck,
    StRetry,
    StDone
  } sysid_state_e;

  typedef enum logic {
    CauseTimeout,
    CauseMismatch
  } sysid_cause_e;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam int unsigned SYSID_WDOG_W  = 8;
  localparam int unsigned SYSID_RETRY_W = 3;

endpackage

// File: rtl/kernel_sysid_checker_if.sv
// Avalon-MM read-only bus between the checker (master) and the system-ID slave.
//   avm_address     : 0 = ID word, 1 = timestamp word
//   avm_read        : held read request
//   avm_readdata    : slave read data
//   avm_waitrequest : slave stall
interface kernel_sysid_checker_if;

  logic        avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_readdata,
    input  avm_waitrequest
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_readdata,
    output avm_waitrequest
  );

endinterface

// File: rtl/kernel_sysid_wdog.sv
// Read-stall watchdog: counts stalled cycles and flags the LIMIT-th one.
//   clock, reset_n : clock, synchronous active-low reset
//   clear          : reload the count to zero (takes priority over enable)
//   enable         : count this cycle as stalled
//   expired        : this enabled cycle is the LIMIT-th stalled cycle
module kernel_sysid_wdog
  import kernel_sysid_pkg::*;
#(
  parameter int unsigned LIMIT = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [SYSID_WDOG_W-1:0] LastCount = SYSID_WDOG_W'(LIMIT - 1);

  logic [SYSID_WDOG_W-1:0] count_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + 1'b1;
    end
  end

  // Combinational so the FSM can leave the read state on the very stall that hits the limit.
  assign expired = enable && !clear && (count_q == LastCount);

endmodule

// File: rtl/kernel_sysid_checker.sv
// Boot-time system-ID checker. Reads word 0 (system ID) and word 1 (build
// timestamp) from the system-ID slave, compares against EXPECTED_ID/EXPECTED_TS,
// retries up to MAX_RETRIES times on timeout or mismatch, and releases the CPU
// once a check passes.
// Ports:
//   clock, reset_n     : clock, synchronous active-low reset
//   start              : one-cycle launch pulse, ignored while busy or in the done cycle
//   avm                : Avalon-MM master (address/read out, readdata/waitrequest in)
//   busy, done         : check in progress / one-cycle verdict pulse
//   pass, fail_timeout, fail_mismatch : sticky verdict of the last check
//   cpu_release        : set by a passing check, cleared only by reset
//   id_captured, ts_captured : last words read at address 0 / 1
//   retry_count        : retries consumed by the current/last check
// Optional build macro: SYSID_AUTOSTART_EN launches a check in the first cycle
// after reset is released.
module kernel_sysid_checker
  import kernel_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS    = 32'd1485236220,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      start,
  kernel_sysid_checker_if.master    avm,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic                      fail_timeout,
  output logic                      fail_mismatch,
  output logic                      cpu_release,
  output logic [31:0]               id_captured,
  output logic [31:0]               ts_captured,
  output logic [SYSID_RETRY_W-1:0]  retry_count
);

  localparam logic [SYSID_RETRY_W-1:0] MaxRetries = SYSID_RETRY_W'(MAX_RETRIES);

  sysid_state_e             state_q, state_d;
  sysid_cause_e             cause_q, cause_d;
  logic                     read_q, read_d;
  logic                     addr_q, addr_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     pass_q, pass_d;
  logic                     fail_to_q, fail_to_d;
  logic                     fail_mm_q, fail_mm_d;
  logic                     release_q, release_d;
  logic [31:0]              id_q, id_d;
  logic [31:0]              ts_q, ts_d;
  logic [SYSID_RETRY_W-1:0] retry_q, retry_d;

  logic start_int;
  logic rd_done;
  logic wd_clear;
  logic wd_enable;
  logic wd_expired;

`ifdef SYSID_AUTOSTART_EN
  // Low only in the first cycle after reset release; that cycle acts as a start pulse.
  logic boot_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      boot_q <= 1'b0;
    end else begin
      boot_q <= 1'b1;
    end
  end

  assign start_int = start || !boot_q;
`else
  assign start_int = start;
`endif

  // read_q is high in both read states, so this marks the accepted beat.
  assign rd_done = read_q && !avm.avm_waitrequest;

  kernel_sysid_wdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wdog (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    pass_d    = pass_q;
    fail_to_d = fail_to_q;
    fail_mm_d = fail_mm_q;
    release_d = release_q;
    id_d      = id_q;
    ts_d      = ts_q;
    retry_d   = retry_q;
    wd_clear  = 1'b0;
    wd_enable = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_int) begin
          state_d   = StRdId;
          retry_d   = '0;
          pass_d    = 1'b0;
          fail_to_d = 1'b0;
          fail_mm_d = 1'b0;
          wd_clear  = 1'b1;
        end
      end

      StRdId: begin
        if (rd_done) begin
          id_d     = avm.avm_readdata;
          state_d  = StRdTs;
          wd_clear = 1'b1;
        end else begin
          wd_enable = 1'b1;
          if (wd_expired) begin
            cause_d = CauseTimeout;
            state_d = StRetry;
          end
        end
      end

      StRdTs: begin
        if (rd_done) begin
          ts_d    = avm.avm_readdata;
          state_d = StCheck;
        end else begin
          wd_enable = 1'b1;
          if (wd_expired) begin
            cause_d = CauseTimeout;
            state_d = StRetry;
          end
        end
      end

      StCheck: begin
        if ((id_q == EXPECTED_ID) && (ts_q == EXPECTED_TS)) begin
          // Verdict and release become visible together with done.
          pass_d    = 1'b1;
          release_d = 1'b1;
          state_d   = StDone;
        end else begin
          cause_d = CauseMismatch;
          state_d = StRetry;
        end
      end

      StRetry: begin
        if (retry_q < MaxRetries) begin
          retry_d  = retry_q + 1'b1;
          state_d  = StRdId;
          wd_clear = 1'b1;
        end else begin
          fail_to_d = (cause_q == CauseTimeout);
          fail_mm_d = (cause_q == CauseMismatch);
          state_d   = StDone;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Bus and status outputs are registered from the next state.
    read_d = (state_d == StRdId) || (state_d == StRdTs);
    addr_d = (state_d == StRdTs) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
    busy_d = (state_d != StIdle) && (state_d != StDone);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      cause_q   <= CauseTimeout;
      read_q    <= 1'b0;
      addr_q    <= SYSID_ADDR_ID;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      fail_to_q <= 1'b0;
      fail_mm_q <= 1'b0;
      release_q <= 1'b0;
      id_q      <= '0;
      ts_q      <= '0;
      retry_q   <= '0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      read_q    <= read_d;
      addr_q    <= addr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      fail_to_q <= fail_to_d;
      fail_mm_q <= fail_mm_d;
      release_q <= release_d;
      id_q      <= id_d;
      ts_q      <= ts_d;
      retry_q   <= retry_d;
    end
  end

  assign avm.avm_read    = read_q;
  assign avm.avm_address = addr_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign fail_timeout    = fail_to_q;
  assign fail_mismatch   = fail_mm_q;
  assign cpu_release     = release_q;
  assign id_captured     = id_q;
  assign ts_captured     = ts_q;
  assign retry_count     = retry_q;

endmodule

// File: tb/tb_kernel_sysid_checker.sv
// Self-checking bench for kernel_sysid_checker (default build, autostart off).
module tb_kernel_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'h0000_0000;
  localparam logic [31:0] EXP_TS = 32'd1485236220;
  localparam int          TMO    = 16;
  localparam int          MAXR   = 3;
  localparam int          BOUND  = 1000;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, pass, fail_timeout, fail_mismatch, cpu_release;
  logic [31:0] id_captured, ts_captured;
  logic [2:0]  retry_count;

  kernel_sysid_checker_if avm_bus ();

  kernel_sysid_checker #(
    .EXPECTED_ID    (EXP_ID),
    .EXPECTED_TS    (EXP_TS),
    .TIMEOUT_CYCLES (TMO),
    .MAX_RETRIES    (MAXR)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .start         (start),
    .avm           (avm_bus.master),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .fail_timeout  (fail_timeout),
    .fail_mismatch (fail_mismatch),
    .cpu_release   (cpu_release),
    .id_captured   (id_captured),
    .ts_captured   (ts_captured),
    .retry_count   (retry_count)
  );

  always #5 clock = ~clock;

  // Slave model: stalls each read for stall_n cycles, then returns the word.
  int          stall_n = 0;
  int          st_cnt = 0;
  logic [31:0] sl_id = 32'h0;
  logic [31:0] sl_ts = 32'h0;

  always_comb begin
    avm_bus.avm_waitrequest = avm_bus.avm_read && (st_cnt < stall_n);
    avm_bus.avm_readdata    = avm_bus.avm_address ? sl_ts : sl_id;
  end

  always @(posedge clock) begin
    if (!avm_bus.avm_read || !avm_bus.avm_waitrequest) st_cnt <= 0;
    else st_cnt <= st_cnt + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state carried across checks.
  logic [31:0] m_id_cap, m_ts_cap;
  bit          m_release;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Outcome of one check from the slave's behaviour: each attempt either times
  // out after TMO stalled cycles in the ID read, or reads both words
  // ((s+1) cycles each) and spends one compare cycle; failures add a retry cycle.
  task automatic model_check(input logic [31:0] id, input logic [31:0] ts, input int s,
                             output bit e_pass, output bit e_ft, output bit e_fm,
                             output int e_retry, output int e_lat);
    e_pass = 0; e_ft = 0; e_fm = 0; e_retry = 0; e_lat = 0;
    for (int a = 0; a <= MAXR; a++) begin
      e_retry = a;
      if (s >= TMO) begin
        e_lat += TMO;
        e_ft = 1; e_fm = 0;
      end else begin
        e_lat += 2 * (s + 1) + 1;
        m_id_cap = id;
        m_ts_cap = ts;
        if (id == EXP_ID && ts == EXP_TS) begin
          e_pass = 1; e_ft = 0; e_fm = 0;
          m_release = 1;
          return;
        end
        e_ft = 0; e_fm = 1;
      end
      e_lat += 1;
    end
  endtask

  // Pulse start and count edges until done (lat = cycles spent before the done cycle).
  task automatic start_and_wait(output int lat);
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    while (!done && lat < BOUND) begin
      tick();
      lat++;
    end
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    m_id_cap = 0; m_ts_cap = 0; m_release = 0;
  endtask

  task automatic test_reset();
    logic [77:0] obs;
    reset_n = 1'b0;
    start = 1'b0;
    tick();
    tick();
    obs = {avm_bus.avm_read, avm_bus.avm_address, busy, done, pass, fail_timeout,
           fail_mismatch, cpu_release, retry_count, id_captured, ts_captured};
    if (obs !== '0) begin
      $display("FAIL reset_outputs: got %h, want 0", obs);
      n_bad++;
    end
    n_cmp++;
    reset_n = 1'b1;
    m_id_cap = 0; m_ts_cap = 0; m_release = 0;
    tick();
  endtask

  task automatic test_zero_wait_pass();
    logic [5:0] obs;
    sl_id = EXP_ID; sl_ts = EXP_TS; stall_n = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    obs[5:4] = {avm_bus.avm_read, avm_bus.avm_address};
    tick();
    obs[3:2] = {avm_bus.avm_read, avm_bus.avm_address};
    tick();
    obs[1] = avm_bus.avm_read;
    tick();
    obs[0] = done;
    if (obs !== 6'b10_11_0_1) begin
      $display("FAIL zero_wait_timing: read/addr/done seq %b, want 101101", obs);
      n_bad++;
    end
    n_cmp++;
    if ({pass, cpu_release, fail_timeout, fail_mismatch, retry_count, busy} !== 8'b1100_000_0) begin
      $display("FAIL zero_wait_verdict: p/r/ft/fm/rc/busy %b, want 11000000",
               {pass, cpu_release, fail_timeout, fail_mismatch, retry_count, busy});
      n_bad++;
    end
    n_cmp++;
    m_id_cap = EXP_ID; m_ts_cap = EXP_TS; m_release = 1;
    tick();
    if (done !== 1'b0 || pass !== 1'b1) begin
      $display("FAIL done_pulse: done=%b pass=%b, want done=0 pass=1", done, pass);
      n_bad++;
    end
    n_cmp++;
  endtask

  // One full check with a given slave behaviour, compared with the model.
  task automatic scenario(input string name, input logic [31:0] id, input logic [31:0] ts,
                          input int s);
    bit e_pass, e_ft, e_fm;
    int e_retry, e_lat, lat;
    sl_id = id; sl_ts = ts; stall_n = s;
    model_check(id, ts, s, e_pass, e_ft, e_fm, e_retry, e_lat);
    start_and_wait(lat);
    if (lat !== e_lat || done !== 1'b1) begin
      $display("FAIL %s_latency: got %0d (done=%b), want %0d", name, lat, done, e_lat);
      n_bad++;
    end
    n_cmp++;
    if ({pass, fail_timeout, fail_mismatch, cpu_release, retry_count} !==
        {e_pass, e_ft, e_fm, m_release, 3'(e_retry)}) begin
      $display("FAIL %s_verdict: p/ft/fm/rel/rc got %b, want %b", name,
               {pass, fail_timeout, fail_mismatch, cpu_release, retry_count},
               {e_pass, e_ft, e_fm, m_release, 3'(e_retry)});
      n_bad++;
    end
    n_cmp++;
    if (id_captured !== m_id_cap || ts_captured !== m_ts_cap) begin
      $display("FAIL %s_capture: got %h/%h, want %h/%h", name, id_captured, ts_captured,
               m_id_cap, m_ts_cap);
      n_bad++;
    end
    n_cmp++;
    tick();
  endtask

  task automatic test_mismatch();
    apply_reset();
    scenario("mismatch", 32'h0000_0001, EXP_TS, 0);
  endtask

  task automatic test_timeout();
    apply_reset();
    scenario("timeout", EXP_ID, EXP_TS, 100000);
  endtask

  task automatic test_stall_pass();
    int bad = 0;
    bit e_pass, e_ft, e_fm;
    int e_retry, e_lat;
    apply_reset();
    sl_id = EXP_ID; sl_ts = EXP_TS; stall_n = 5;
    model_check(EXP_ID, EXP_TS, 5, e_pass, e_ft, e_fm, e_retry, e_lat);
    start = 1'b1;
    tick();
    start = 1'b0;
    // 6 cycles on address 0, then 6 on address 1, read held throughout.
    for (int k = 0; k < 12; k++) begin
      if (avm_bus.avm_read !== 1'b1 || avm_bus.avm_address !== (k >= 6)) bad++;
      tick();
    end
    if (bad != 0) begin
      $display("FAIL stall_addr_stable: %0d bad cycles, want 0", bad);
      n_bad++;
    end
    n_cmp++;
    tick();
    if ({done, pass, retry_count} !== {1'b1, 1'b1, 3'd0} || e_lat != 13) begin
      $display("FAIL stall_pass: done/pass/rc %b, want 11000", {done, pass, retry_count});
      n_bad++;
    end
    n_cmp++;
    tick();
  endtask

  task automatic test_reset_mid_read();
    logic [77:0] obs;
    apply_reset();
    sl_id = EXP_ID; sl_ts = EXP_TS; stall_n = 5;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    if ({avm_bus.avm_read, avm_bus.avm_address} !== 2'b11) begin
      $display("FAIL midread_in_rdts: read/addr %b, want 11", {avm_bus.avm_read, avm_bus.avm_address});
      n_bad++;
    end
    n_cmp++;
    reset_n = 1'b0;
    tick();
    obs = {avm_bus.avm_read, avm_bus.avm_address, busy, done, pass, fail_timeout,
           fail_mismatch, cpu_release, retry_count, id_captured, ts_captured};
    if (obs !== '0) begin
      $display("FAIL midread_reset: got %h, want 0", obs);
      n_bad++;
    end
    n_cmp++;
    reset_n = 1'b1;
    m_id_cap = 0; m_ts_cap = 0; m_release = 0;
    tick();
    scenario("after_reset", EXP_ID, EXP_TS, 0);
  endtask

  task automatic test_busy_start();
    int lat;
    bit e_pass, e_ft, e_fm;
    int e_retry, e_lat;
    sl_id = EXP_ID; sl_ts = EXP_TS; stall_n = 2;
    model_check(EXP_ID, EXP_TS, 2, e_pass, e_ft, e_fm, e_retry, e_lat);
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    while (!done && lat < BOUND) begin
      start = (lat == 1 || lat == 3);
      tick();
      lat++;
    end
    start = 1'b0;
    if (lat !== e_lat) begin
      $display("FAIL busy_start_latency: got %0d, want %0d", lat, e_lat);
      n_bad++;
    end
    n_cmp++;
    // Start in the done cycle is dropped.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    if ({busy, done, avm_bus.avm_read} !== 3'b000) begin
      $display("FAIL start_at_done: busy/done/read %b, want 000", {busy, done, avm_bus.avm_read});
      n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_release_sticky();
    apply_reset();
    scenario("sticky_pass", EXP_ID, EXP_TS, 1);
    scenario("sticky_fail", EXP_ID, 32'h1234_5678, 0);
  endtask

  task automatic test_random();
    int s;
    logic [31:0] id, ts;
    int stalls[8] = '{0, 1, 3, 5, 14, 15, 16, 40};
    for (int i = 0; i < 10; i++) begin
      id = ($urandom_range(0, 2) == 0) ? $urandom() : EXP_ID;
      ts = ($urandom_range(0, 2) == 0) ? $urandom() : EXP_TS;
      s = stalls[$urandom_range(0, 7)];
      scenario($sformatf("rand%0d", i), id, ts, s);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait_pass();
    test_busy_start();
    test_mismatch();
    test_timeout();
    test_stall_pass();
    test_reset_mid_read();
    test_release_sticky();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
